// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debounce, press/release/long
// pulses and a wrapping press counter. All outputs are registered.
module btn_debounce #(
    parameter int unsigned DB_CYCLES   = 250000,
    parameter int unsigned LONG_CYCLES = 125000000,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 btn_i,
    output logic                 btn_o,
    output logic                 press_o,
    output logic                 release_o,
    output logic                 long_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int unsigned DbW   = $clog2(DB_CYCLES);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

    logic                 s1_q, s2_q;
    logic [DbW-1:0]       db_cnt_q, db_cnt_d;
    logic                 btn_q, btn_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    state_e               state_q, state_d;

    logic s_diff, db_done, rise, fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_cnt_q  <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
            hold_q    <= '0;
            state_q   <= StIdle;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            db_cnt_q  <= db_cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

    // Debounce: a level is accepted once s2 has differed from btn_q for DB_CYCLES samples.
    always_comb begin
        s_diff    = s2_q ^ btn_q;
        db_done   = s_diff && (db_cnt_q == DbLast);
        rise      = db_done && s2_q;
        fall      = db_done && !s2_q;

        db_cnt_d  = '0;
        btn_d     = btn_q;
        press_d   = rise;
        release_d = fall;
        count_d   = count_q;

        if (s_diff && !db_done) begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
        if (db_done) begin
            btn_d = s2_q;
        end
        if (rise) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Long-press tracking; an accepted release on the same edge wins over long_o.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (rise) begin
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end else if (hold_q == HoldLast) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StLong: begin
                if (fall) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=4, LONG_CYCLES=10, CNT_WIDTH=2.
module tb_btn_debounce;

    localparam int unsigned DbCycles   = 4;
    localparam int unsigned LongCycles = 10;
    localparam int unsigned CntWidth   = 2;

    logic                clk_i  = 1'b0;
    logic                rst_ni = 1'b1;
    logic                btn_i  = 1'b0;
    logic                btn_o, press_o, release_o, long_o;
    logic [CntWidth-1:0] count_o;
    logic [3:0]          flags;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;
    int l0, r0;

    btn_debounce #(
        .DB_CYCLES  (DbCycles),
        .LONG_CYCLES(LongCycles),
        .CNT_WIDTH  (CntWidth)
    ) u_dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .btn_i    (btn_i),
        .btn_o    (btn_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .count_o  (count_o)
    );

    always #5 clk_i = ~clk_i;

    assign flags = {btn_o, press_o, release_o, long_o};

    always @(negedge clk_i) begin
        if (press_o)   n_press++;
        if (release_o) n_rel++;
        if (long_o)    n_long++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with the pin toggling: every output held at zero.
        #2 rst_ni = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_i = i[0];
            tick();
            check_eq("rst_flags", 32'(flags), 32'h0);
            check_eq("rst_count", 32'(count_o), 32'h0);
        end
        btn_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        check_eq("idle_flags", 32'(flags), 32'h0);

        // 3-cycle high glitches on a released button.
        repeat (5) begin
            btn_i = 1'b1;
            repeat (3) begin
                tick();
                check_eq("glitch_lo_btn", 32'(btn_o), 32'h0);
            end
            btn_i = 1'b0;
            repeat (4) begin
                tick();
                check_eq("glitch_lo_btn", 32'(btn_o), 32'h0);
            end
        end
        check_eq("glitch_lo_press", 32'(n_press), 32'd0);
        check_eq("glitch_lo_rel", 32'(n_rel), 32'd0);
        check_eq("glitch_lo_count", 32'(count_o), 32'd0);

        // Clean press: accepted on the 5th edge after the first sampling edge.
        btn_i = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check_eq("press_wait", 32'(flags), 32'h0);
        end
        tick();
        check_eq("press_edge", 32'(flags), 32'b1100);
        check_eq("press_count", 32'(count_o), 32'd1);
        tick();
        check_eq("press_after", 32'(flags), 32'b1000);
        for (int e = 8; e <= 15; e++) begin
            tick();
            check_eq("long_wait", 32'(long_o), 32'h0);
        end
        tick();
        check_eq("long_edge", 32'(flags), 32'b1001);
        tick();
        check_eq("long_after", 32'(flags), 32'b1000);
        repeat (30) tick();
        check_eq("long_once", 32'(n_long), 32'd1);

        // 3-cycle low drops on a held button.
        repeat (5) begin
            btn_i = 1'b0;
            repeat (3) begin
                tick();
                check_eq("glitch_hi_btn", 32'(btn_o), 32'h1);
            end
            btn_i = 1'b1;
            repeat (4) begin
                tick();
                check_eq("glitch_hi_btn", 32'(btn_o), 32'h1);
            end
        end
        check_eq("glitch_hi_rel", 32'(n_rel), 32'd0);
        check_eq("glitch_hi_long", 32'(n_long), 32'd1);

        // Release after the long press.
        btn_i = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check_eq("rel_wait", 32'(flags), 32'b1000);
        end
        tick();
        check_eq("rel_edge", 32'(flags), 32'b0010);
        check_eq("rel_count", 32'(count_o), 32'd1);
        tick();
        check_eq("rel_after", 32'(flags), 32'h0);
        repeat (4) tick();

        // Release lands on the edge that would fire long_o: release wins.
        btn_i = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 10) btn_i = 1'b0;
            if (e == 6)  check_eq("coll_press", 32'(flags), 32'b1100);
            if (e == 16) check_eq("coll_edge", 32'(flags), 32'b0010);
        end
        check_eq("coll_long", 32'(n_long), 32'd1);
        check_eq("coll_rel", 32'(n_rel), 32'd2);
        check_eq("coll_count", 32'(count_o), 32'd2);

        // Short presses from a fresh reset: count 1,2,3,0.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        check_eq("wrap_start", 32'(count_o), 32'd0);
        l0 = n_long;
        r0 = n_rel;
        for (int p = 0; p < 4; p++) begin
            btn_i = 1'b1;
            for (int e = 1; e <= 18; e++) begin
                tick();
                if (e == 6) begin
                    btn_i = 1'b0;
                    check_eq("wrap_press", 32'(press_o), 32'h1);
                    check_eq("wrap_count", 32'(count_o), 32'((p + 1) % 4));
                end
                if (e == 12) check_eq("wrap_rel", 32'(flags), 32'b0010);
            end
        end
        check_eq("wrap_long", 32'(n_long - l0), 32'd0);
        check_eq("wrap_rels", 32'(n_rel - r0), 32'd4);
        check_eq("wrap_final", 32'(count_o), 32'd0);

        // Reset while in the held state, button kept down across reset release.
        btn_i = 1'b1;
        repeat (9) tick();
        check_eq("mid_btn", 32'(btn_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_flags", 32'(flags), 32'h0);
        check_eq("mid_rst_count", 32'(count_o), 32'h0);
        repeat (2) tick();
        check_eq("mid_rst_hold", 32'(flags), 32'h0);
        rst_ni = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check_eq("mid_wait", 32'(flags), 32'h0);
        end
        tick();
        check_eq("mid_press", 32'(flags), 32'b1100);
        check_eq("mid_count", 32'(count_o), 32'd1);
        for (int e = 7; e <= 15; e++) begin
            tick();
            check_eq("mid_long_wait", 32'(long_o), 32'h0);
        end
        tick();
        check_eq("mid_long", 32'(flags), 32'b1001);
        btn_i = 1'b0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Input-side counterpart to the LED drivers. It conditions one raw mechanical push-button input for the fabric. The raw pin is synchronised, debounced with a stability counter, and turned into a clean level plus single-cycle press, release and long-press pulses. A wrapping press counter is included for status/LED display. One instance is placed per board button, between the top-level pin and the user logic.

Parameters:
DB_CYCLES, 250000, consecutive stable cycles required to accept a new level (2 ms at 125 MHz); legal range >= 2.
LONG_CYCLES, 125000000, cycles after the press pulse at which long_o fires (1 s at 125 MHz); legal range >= 2.
CNT_WIDTH, 8, width of press counter count_o.

Ports:
clk_i      input   1          system clock; the only clock
rst_ni     input   1          reset, asynchronous, active-low
btn_i      input   1          raw button pin, asynchronous to clk_i, active-high
btn_o      output  1          debounced button level
press_o    output  1          1-cycle pulse on accepted 0->1
release_o  output  1          1-cycle pulse on accepted 1->0
long_o     output  1          1-cycle pulse, once per press held LONG_CYCLES
count_o    output  CNT_WIDTH  number of accepted presses, modulo 2^CNT_WIDTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_ni=0):
  - Immediately clears the synchroniser flops, debounce counter, hold counter, FSM (IDLE) and count_o.
  - All outputs are 0 while in reset.
- Synchroniser: 2 flops, btn_i -> s1 -> s2. Only s2 is used downstream.
- Debounce:
  - db_cnt is sized $clog2(DB_CYCLES).
  - If s2 == btn_o, db_cnt is cleared.
  - If s2 != btn_o and db_cnt != DB_CYCLES-1, db_cnt increments.
  - If s2 != btn_o and db_cnt == DB_CYCLES-1, then at that edge btn_o <= s2 and db_cnt is cleared.
- Debounce latency:
  - A clean level change is accepted DB_CYCLES+1 rising edges after edge E0, where E0 is the first edge that samples the new btn_i level into s1.
  - Any excursion shorter than that which returns to the old level leaves btn_o unchanged and clears db_cnt.
- press_o / release_o:
  - Registered; asserted exactly in the first cycle btn_o shows its new value, for one cycle only.
  - Never both high together.
- count_o:
  - Increments by 1 on the same edge that sets press_o.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Long-press FSM (hold_cnt sized $clog2(LONG_CYCLES+1)):
  - IDLE: hold_cnt=0. An accepted press moves to HELD with hold_cnt=0.
  - HELD: hold_cnt increments each cycle. When hold_cnt reaches LONG_CYCLES-1 → LONG and long_o=1 for one cycle. long_o is therefore high exactly LONG_CYCLES cycles after the press_o cycle. An accepted release → IDLE, with no long_o.
  - LONG: no further long_o. An accepted release → IDLE.
- Simultaneous events: release acceptance takes priority over long_o on the same edge; long_o is suppressed.
- Reset mid-operation: everything is cleared. If the button is held through reset release, this is a new press: btn_o rises DB_CYCLES+1 edges later, press_o fires, and count_o=1.
- No combinational path from btn_i to any output.

Test Plan:
- Parameters for all tests: DB_CYCLES=4, LONG_CYCLES=10, CNT_WIDTH=2.
- Reset: rst_ni=0 with btn_i toggling -> btn_o, press_o, release_o, long_o =0 and count_o=0 throughout reset.
- Clean press: btn_i 0->1 held -> btn_o=1 at the 5th edge after E0; press_o=1 for exactly that cycle; count_o=1; release_o=0.
- Glitch rejection: btn_i high for 3 cycles, then low, repeated 5 times -> btn_o stays 0, no pulses, count_o=0. Same test on a held-high button with 3-cycle low drops -> btn_o stays 1, no release_o.
- Long press: hold btn_i -> long_o high exactly 10 cycles after the press_o cycle, for 1 cycle. Keep holding 30 more cycles -> no second long_o. Release -> release_o after 5 edges, FSM returns to IDLE.
- Short press / wrap: 4 presses each held 6 cycles -> count_o sequence 1,2,3,0; long_o never asserted; 4 release_o pulses.
- Reset mid-hold: assert rst_ni=0 in HELD -> outputs 0 immediately. Deassert with btn_i still 1 -> press_o after 5 edges, count_o=1, long_o 10 cycles later.
